// File: rtl/cluster_clk_seq.sv
`default_nettype none
// ============================================================================
// Module   : cluster_clk_seq
// Purpose  : Staggered cluster clock-enable ramp, reset/debug-init release and
//            run-time clock-stop handshake for a row of cluster clock headers.
//            Optional scan bypass: CLUSTER_CLK_SEQ_SCAN_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_clk_seq #(
    parameter int NUM_CL   = 4,
    parameter int STAGGER  = 4,
    parameter int RST_HOLD = 16,
    parameter int DBG_HOLD = 8
) (
    input  logic              gclk,
    input  logic              grst,
    input  logic              dbg_req,
    input  logic [NUM_CL-1:0] stop_req,
    input  logic              se,
    output logic [NUM_CL-1:0] cluster_cken,
    output logic              grst_l,
    output logic              gdbginit_l,
    output logic [NUM_CL-1:0] stop_ack,
    output logic              seq_done
);

    localparam int C_MAX_HOLD = (STAGGER > RST_HOLD)
                              ? ((STAGGER > DBG_HOLD) ? STAGGER : DBG_HOLD)
                              : ((RST_HOLD > DBG_HOLD) ? RST_HOLD : DBG_HOLD);
    localparam int CNT_W = $clog2(C_MAX_HOLD) + 1;
    localparam int IDX_W = $clog2(NUM_CL + 1);

    typedef enum logic [1:0] {
        S_RAMP = 2'd0,
        S_HOLD = 2'd1,
        S_DBG  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [NUM_CL-1:0]   cken_q,   cken_d;
    logic [NUM_CL-1:0]   ack_q,    ack_d;
    logic                grst_l_q, grst_l_d;
    logic                dbg_l_q,  dbg_l_d;
    logic                done_q,   done_d;

    logic [NUM_CL-1:0]   w_stop_set;
    logic [NUM_CL-1:0]   w_stop_clr;

    // A new stop request and a released request are independent per cluster
    assign w_stop_set = stop_req & ~ack_q;
    assign w_stop_clr = ~stop_req & ack_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cken_d   = cken_q;
        ack_d    = ack_q;
        grst_l_d = grst_l_q;
        dbg_l_d  = dbg_l_q;
        done_d   = done_q;
        case (state_q)
            S_RAMP: begin
                if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_CL; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            cken_d[i] = 1'b1;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_CL - 1)) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    cnt_d    = '0;
                    grst_l_d = 1'b1;
                    state_d  = S_DBG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DBG: begin
                // Clock-stop state stays frozen here; pending requests wait for RUN
                if (cnt_q == CNT_W'(DBG_HOLD - 1)) begin
                    cnt_d   = '0;
                    dbg_l_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                ack_d  = ack_q ^ (w_stop_set | w_stop_clr);
                cken_d = (cken_q & ~w_stop_set) | w_stop_clr;
                if (dbg_req) begin
                    cnt_d   = '0;
                    dbg_l_d = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_DBG;
                end
            end
            default: begin
                state_d = S_RAMP;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q  <= S_RAMP;
            cnt_q    <= '0;
            idx_q    <= '0;
            cken_q   <= '0;
            ack_q    <= '0;
            grst_l_q <= 1'b0;
            dbg_l_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            cken_q   <= cken_d;
            ack_q    <= ack_d;
            grst_l_q <= grst_l_d;
            dbg_l_q  <= dbg_l_d;
            done_q   <= done_d;
        end
    end

`ifdef CLUSTER_CLK_SEQ_SCAN_BYPASS_EN
    // Scan forces headers on and out of reset without disturbing the sequencer
    assign cluster_cken = se ? {NUM_CL{1'b1}} : cken_q;
    assign grst_l       = se | grst_l_q;
`else
    logic w_unused_se;
    assign w_unused_se  = se;
    assign cluster_cken = cken_q;
    assign grst_l       = grst_l_q;
`endif

    assign gdbginit_l = dbg_l_q;
    assign stop_ack   = ack_q;
    assign seq_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_clk_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_clk_seq
// Purpose  : Directed self-checking bench for cluster_clk_seq (default params).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cluster_clk_seq;

    localparam int NUM_CL = 4;

    logic              gclk;
    logic              grst;
    logic              dbg_req;
    logic [NUM_CL-1:0] stop_req;
    logic              se;
    logic [NUM_CL-1:0] cluster_cken;
    logic              grst_l;
    logic              gdbginit_l;
    logic [NUM_CL-1:0] stop_ack;
    logic              seq_done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    cluster_clk_seq #(
        .NUM_CL   (NUM_CL),
        .STAGGER  (4),
        .RST_HOLD (16),
        .DBG_HOLD (8)
    ) u_dut (
        .gclk         (gclk),
        .grst         (grst),
        .dbg_req      (dbg_req),
        .stop_req     (stop_req),
        .se           (se),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .stop_ack     (stop_ack),
        .seq_done     (seq_done)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // cyc counts edges sampled with grst low; sampling is 1ns after the edge
    task automatic tick();
        @(posedge gclk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cken"}, 32'(cluster_cken), 32'h0);
        check_val({tag, "_grst_l"}, 32'(grst_l), 32'h0);
        check_val({tag, "_dbg_l"}, 32'(gdbginit_l), 32'h0);
        check_val({tag, "_ack"}, 32'(stop_ack), 32'h0);
        check_val({tag, "_done"}, 32'(seq_done), 32'h0);
    endtask

    task automatic apply_reset(input logic [NUM_CL-1:0] req);
        grst     = 1'b1;
        dbg_req  = 1'b0;
        se       = 1'b0;
        stop_req = req;
        repeat (3) tick();
        check_reset_outputs("reset");
        grst = 1'b0;
        cyc  = 0;
    endtask

    initial begin
        grst     = 1'b1;
        dbg_req  = 1'b0;
        stop_req = '0;
        se       = 1'b0;

        // Power-up ramp, stop handshake, debug init with a stopped cluster
        apply_reset(4'b0000);
        goto(3);  check_val("ramp_c3", 32'(cluster_cken), 32'h0);
        goto(4);  check_val("ramp_c4", 32'(cluster_cken), 32'h1);
        goto(7);  check_val("ramp_c7", 32'(cluster_cken), 32'h1);
        goto(8);  check_val("ramp_c8", 32'(cluster_cken), 32'h3);
        goto(12); check_val("ramp_c12", 32'(cluster_cken), 32'h7);
        goto(16); check_val("ramp_c16", 32'(cluster_cken), 32'hF);
        goto(31); check_val("hold_grst_c31", 32'(grst_l), 32'h0);
        goto(32); check_val("rel_grst_c32", 32'(grst_l), 32'h1);
                  check_val("dbg_c32", 32'(gdbginit_l), 32'h0);
        goto(39); check_val("dbg_c39", 32'(gdbginit_l), 32'h0);
                  check_val("done_c39", 32'(seq_done), 32'h0);
        goto(40); check_val("dbg_c40", 32'(gdbginit_l), 32'h1);
                  check_val("done_c40", 32'(seq_done), 32'h1);

        goto(50); stop_req = 4'b0100;
        goto(51); check_val("stop_cken_c51", 32'(cluster_cken), 32'hB);
                  check_val("stop_ack_c51", 32'(stop_ack), 32'h4);
        goto(60); stop_req = 4'b0000;
        goto(61); check_val("start_cken_c61", 32'(cluster_cken), 32'hF);
                  check_val("start_ack_c61", 32'(stop_ack), 32'h0);

        goto(65); stop_req = 4'b0010;
        goto(66); check_val("stop1_cken_c66", 32'(cluster_cken), 32'hD);
        goto(70); dbg_req = 1'b1;
        tick();   dbg_req = 1'b0;
                  check_val("dinit_dbg_c71", 32'(gdbginit_l), 32'h0);
                  check_val("dinit_done_c71", 32'(seq_done), 32'h0);
                  check_val("dinit_grst_c71", 32'(grst_l), 32'h1);
        goto(74); stop_req = 4'b1010;
        goto(78); check_val("dinit_dbg_c78", 32'(gdbginit_l), 32'h0);
                  check_val("frozen_cken_c78", 32'(cluster_cken), 32'hD);
                  check_val("frozen_ack_c78", 32'(stop_ack), 32'h2);
        goto(79); check_val("dinit_dbg_c79", 32'(gdbginit_l), 32'h1);
                  check_val("dinit_done_c79", 32'(seq_done), 32'h1);
                  check_val("exit_cken_c79", 32'(cluster_cken), 32'hD);
        goto(80); check_val("pend_cken_c80", 32'(cluster_cken), 32'h5);
                  check_val("pend_ack_c80", 32'(stop_ack), 32'hA);

        // Requests before RUN are ignored
        apply_reset(4'b1111);
        goto(10); dbg_req = 1'b1;
        tick();   dbg_req = 1'b0;
        goto(16); check_val("ign_cken_c16", 32'(cluster_cken), 32'hF);
                  check_val("ign_ack_c16", 32'(stop_ack), 32'h0);
        goto(39); check_val("ign_ack_c39", 32'(stop_ack), 32'h0);
        goto(40); check_val("ign_done_c40", 32'(seq_done), 32'h1);
                  check_val("ign_dbg_c40", 32'(gdbginit_l), 32'h1);
                  check_val("ign_ack_c40", 32'(stop_ack), 32'h0);
        goto(41); check_val("ign_cken_c41", 32'(cluster_cken), 32'h0);
                  check_val("ign_ack_c41", 32'(stop_ack), 32'hF);

        // Reset mid-ramp then identical restart; reset in RUN with a stop pending
        apply_reset(4'b0000);
        goto(9);  check_val("mid_cken_c9", 32'(cluster_cken), 32'h3);
        grst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        grst = 1'b0;
        cyc  = 0;
        goto(3);  check_val("re_cken_c3", 32'(cluster_cken), 32'h0);
        goto(4);  check_val("re_cken_c4", 32'(cluster_cken), 32'h1);
        goto(16); check_val("re_cken_c16", 32'(cluster_cken), 32'hF);
        goto(31); check_val("re_grst_c31", 32'(grst_l), 32'h0);
        goto(32); check_val("re_grst_c32", 32'(grst_l), 32'h1);
        goto(40); check_val("re_done_c40", 32'(seq_done), 32'h1);
        goto(45); stop_req = 4'b0001;
        goto(46); check_val("run_ack_c46", 32'(stop_ack), 32'h1);
        grst = 1'b1;
        tick();
        check_reset_outputs("runrst");

        // Scan enable behaviour
        apply_reset(4'b0000);
        goto(6);
        se = 1'b1;
        #1;
`ifdef CLUSTER_CLK_SEQ_SCAN_BYPASS_EN
        check_val("scan_cken_c6", 32'(cluster_cken), 32'hF);
        check_val("scan_grst_c6", 32'(grst_l), 32'h1);
        goto(20);
        se = 1'b0;
        #1;
        check_val("scan_cken_c20", 32'(cluster_cken), 32'hF);
        check_val("scan_grst_c20", 32'(grst_l), 32'h0);
        goto(31); check_val("scan_grst_c31", 32'(grst_l), 32'h0);
        goto(32); check_val("scan_grst_c32", 32'(grst_l), 32'h1);
`else
        check_val("se_cken_c6", 32'(cluster_cken), 32'h1);
        check_val("se_grst_c6", 32'(grst_l), 32'h0);
        goto(16); check_val("se_cken_c16", 32'(cluster_cken), 32'hF);
        goto(31); check_val("se_grst_c31", 32'(grst_l), 32'h0);
        goto(32); check_val("se_grst_c32", 32'(grst_l), 32'h1);
        se = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
